// File: rtl/shift_pkg.sv
// Shared constants for the shift register and its parallel-to-serial feeder.
package shift_pkg;

  localparam int unsigned SHIFT_W = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder: accepts a word and drives din/sl/sr of the downstream
// shift register for WIDTH presented cycles, with pause and a one-cycle done pulse.
module shift_feeder
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic             hold,
  output logic             sl,
  output logic             sr,
  output logic             din,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sl_q, sl_d, sr_q, sr_d, din_q, din_d;
  logic               busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic               accept, strobe, last;
  logic               next_bit;
  logic [WIDTH-1:0]   word_shifted;

  assign accept       = in_valid & ready_q;
  assign strobe       = sl_q | sr_q;
  assign last         = (cnt_q == CNT_W'(WIDTH - 1));
  assign next_bit     = (dir_q == DIR_RIGHT) ? word_q[0] : word_q[WIDTH-1];
  assign word_shifted = (dir_q == DIR_RIGHT) ? (word_q >> 1) : (word_q << 1);

  // Outputs are registered, so each branch computes what the next cycle presents.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        din_d   = 1'b0;
        if (accept) begin
          state_d = ST_SHIFT;
          dir_d   = dir;
          cnt_d   = '0;
          sl_d    = (dir == DIR_LEFT);
          sr_d    = (dir == DIR_RIGHT);
          din_d   = (dir == DIR_RIGHT) ? data_in[0] : data_in[WIDTH-1];
          word_d  = (dir == DIR_RIGHT) ? (data_in >> 1) : (data_in << 1);
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        busy_d  = 1'b1;
        ready_d = 1'b0;
        if (strobe && last) begin
          state_d = ST_DONE;
          din_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (strobe) cnt_d = cnt_q + 1'b1;
          // A held cycle presents nothing and leaves din on its previous bit.
          if (!hold) begin
            sl_d   = (dir_q == DIR_LEFT);
            sr_d   = (dir_q == DIR_RIGHT);
            din_d  = next_bit;
            word_d = word_shifted;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        din_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign sl       = sl_q;
  assign sr       = sr_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder paired with a behavioural model of the downstream
// left/right shift register.
module tb_shift_feeder;
  import shift_pkg::*;

  localparam int unsigned W = SHIFT_W;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, dir, hold, sl, sr, din, busy, done;
  logic [W-1:0] data_in;
  logic [W-1:0] q = '0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  shift_feeder #(.WIDTH(W), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .dir      (dir),
    .hold     (hold),
    .sl       (sl),
    .sr       (sr),
    .din      (din),
    .busy     (busy),
    .done     (done)
  );

  // Downstream register: left inserts at LSB, right inserts at MSB.
  always @(posedge clk) begin
    if (sl) q <= {q[W-2:0], din};
    else if (sr) q <= {din, q[W-1:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle. Accept cycle counts as cycle 1.
  task automatic run_word(input logic [W-1:0] d, input logic dr, input int hold_after,
                          input int hold_len, input bit keep_valid, input logic [W-1:0] next_d);
    logic [W-1:0] seq, exp_seq;
    int nbits, gap, both, wrongdir, busy_bad, din_bad, done_cyc, hold_left;
    logic last_bit;
    check("ready_before_accept", 32'(in_ready), 32'd1);
    data_in = d; dir = dr; in_valid = 1'b1;
    seq = '0; nbits = 0; gap = 0; both = 0; wrongdir = 0; busy_bad = 0; din_bad = 0;
    done_cyc = 0; hold_left = 0; last_bit = 1'b0;
    for (int cyc = 2; cyc < 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (!keep_valid) begin
        in_valid = 1'b0;
        data_in  = W'($urandom);
        dir      = 1'($urandom);
      end
      if (done) begin
        done_cyc = cyc;
        if (busy !== 1'b0) busy_bad++;
        if (din !== 1'b0) din_bad++;
        if (keep_valid) data_in = next_d;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (sl && sr) both++;
        if (sl || sr) begin
          if (sr !== dr) wrongdir++;
          if (nbits < int'(W)) seq[nbits] = din;
          last_bit = din;
          nbits++;
        end else begin
          gap++;
          if (din !== last_bit) din_bad++;
        end
      end
      if ((sl || sr) && !done && nbits == hold_after) hold_left = hold_len;
      hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
    end
    hold = 1'b0;
    for (int i = 0; i < int'(W); i++) exp_seq[i] = dr ? d[i] : d[int'(W)-1-i];
    check("bit_sequence", 32'(seq), 32'(exp_seq));
    check("strobe_count", nbits, W);
    check("sl_sr_overlap", both, 0);
    check("strobe_direction", wrongdir, 0);
    check("hold_gap_cycles", gap, hold_len);
    check("done_cycle", done_cyc, 10 + hold_len);
    check("busy_profile", busy_bad, 0);
    check("din_hold_and_done", din_bad, 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("ready_after_done", 32'(in_ready), 32'd1);
    check("downstream_q", 32'(q), 32'(d));
  endtask

  logic [W-1:0] last_word, rd, exp_q;
  int           strobes, dones;

  initial begin
    reset = 1'b0; in_valid = 1'b1; data_in = 8'hFF; dir = 1'b0; hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_outs", {27'd0, sl, sr, din, busy, done}, 32'd0);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("no_accept_in_reset", {30'd0, busy, in_ready}, 32'd1);

    run_word(8'hA5, DIR_LEFT, 0, 0, 1'b0, '0);
    run_word(8'h3C, DIR_RIGHT, 0, 0, 1'b0, '0);
    run_word(8'h81, DIR_LEFT, 4, 3, 1'b0, '0);
    run_word(8'h0F, DIR_LEFT, 0, 0, 1'b1, 8'hF0);
    run_word(8'hF0, DIR_LEFT, 0, 0, 1'b0, '0);
    last_word = 8'hF0;

    for (int k = 0; k < 6; k++) begin
      rd = W'($urandom);
      run_word(rd, 1'($urandom), int'($urandom_range(1, W - 1)), int'($urandom_range(0, 2)),
               1'b0, '0);
      last_word = rd;
    end

    // Reset after the third presented bit of a right-shift word.
    data_in = 8'hFF; dir = DIR_RIGHT; in_valid = 1'b1;
    strobes = 0;
    for (int c = 0; c < 20 && strobes < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (sl || sr) strobes++;
    end
    check("strobes_before_reset", strobes, 3);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_outs", {28'd0, sl, sr, busy, done}, 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    exp_q = {3'b111, last_word[W-1:3]};
    check("midrst_partial_q", 32'(q), 32'(exp_q));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
